// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the power-on reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD,
    RUN,
    WAIT_ACK,
    DONE
  } rs_state_e;

  localparam int unsigned RS_CNT_W_DEFAULT = 26;
  localparam int unsigned RS_MAX_CH        = 16;
  localparam int unsigned RS_MAX_CNT_W     = 32;
  localparam int unsigned RS_MAX_DW        = RS_MAX_CH * RS_MAX_CNT_W;

  // Extract stage k's delay from a packed table of cnt_w-wide entries; 0 reads as 1.
  function automatic logic [31:0] f_delay(input logic [RS_MAX_DW-1:0] delays,
                                          input int unsigned          k,
                                          input int unsigned          cnt_w);
    logic [31:0] mask;
    logic [31:0] d;
    mask = (cnt_w >= 32) ? '1 : ((32'd1 << cnt_w) - 32'd1);
    d    = 32'(delays >> (k * cnt_w)) & mask;
    if (d == '0) begin
      d = 32'd1;
    end
    return d;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, reset to 0.
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] meta_d, meta_q;
  logic [W-1:0] sync_d, sync_q;

  // Next values of the two synchroniser stages.
  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
  end

  // Synchroniser flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: releases N_CH active-low resets one at a time,
// each after its own delay and optionally after an acknowledge with timeout.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned           N_CH     = 5,
  parameter int unsigned           CNT_W    = RS_CNT_W_DEFAULT,
  parameter logic [N_CH*CNT_W-1:0] DELAY    = {N_CH{CNT_W'(21'h1FFFFF)}},
  parameter logic [N_CH-1:0]       ACK_MASK = '0,
  parameter logic [31:0]           TIMEOUT  = 32'((64'd1 << CNT_W) - 64'd1)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_restart,
  input  logic [N_CH-1:0]              i_ack,
  output logic [N_CH-1:0]              o_rst_n,
  output logic                         o_done,
  output logic [$clog2(N_CH+1)-1:0]    o_stage,
  output logic [N_CH-1:0]              o_fault
);

  localparam int unsigned      SW      = $clog2(N_CH + 1);
  localparam logic [CNT_W-1:0] TO_TERM = CNT_W'(TIMEOUT - 32'd1);
  localparam logic [SW-1:0]    LAST    = SW'(N_CH - 1);

  if (N_CH < 1 || N_CH > RS_MAX_CH) begin : g_bad_n_ch
    $error("reset_sequencer: N_CH out of range 1..16");
  end
  if (CNT_W < 1 || CNT_W > RS_MAX_CNT_W) begin : g_bad_cnt_w
    $error("reset_sequencer: CNT_W out of range 1..32");
  end
  if (TIMEOUT == 32'd0 || 64'(TIMEOUT) >= (64'd1 << CNT_W)) begin : g_bad_timeout
    $error("reset_sequencer: TIMEOUT must be in 1..2**CNT_W-1");
  end

  // Terminal counter value per stage (clamped delay minus one), constant.
  logic [CNT_W-1:0] term_tab [N_CH];
  for (genvar k = 0; k < N_CH; k++) begin : g_term
    assign term_tab[k] = CNT_W'(f_delay(RS_MAX_DW'(DELAY), k, CNT_W) - 32'd1);
  end

  logic [N_CH-1:0] ack_sync;

  sync_2ff #(
    .W(N_CH)
  ) u_ack_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (i_ack),
    .o_q    (ack_sync)
  );

  rs_state_e        state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [SW-1:0]    stage_d, stage_q;
  logic [N_CH-1:0]  rst_d, rst_q;
  logic             done_d, done_q;
  logic [N_CH-1:0]  fault_d, fault_q;

  logic [CNT_W-1:0] term_sel;
  logic             ack_sel;
  logic             need_ack;
  logic             release_now;
  logic             timed_out;

  // Next-state logic; HOLD with restart low behaves as RUN cycle 1 of stage 0.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stage_d     = stage_q;
    rst_d       = rst_q;
    done_d      = done_q;
    fault_d     = fault_q;
    term_sel    = '0;
    ack_sel     = 1'b0;
    need_ack    = 1'b0;
    release_now = 1'b0;
    timed_out   = 1'b0;

    for (int unsigned i = 0; i < N_CH; i++) begin
      if (SW'(i) == stage_q) begin
        term_sel = term_tab[i];
        ack_sel  = ack_sync[i];
        need_ack = ACK_MASK[i];
      end
    end

    unique case (state_q)
      HOLD, RUN: begin
        state_d = RUN;
        if (cnt_q == term_sel) begin
          cnt_d = '0;
          if (!need_ack || ack_sel) begin
            release_now = 1'b1;
          end else begin
            state_d = WAIT_ACK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_ACK: begin
        if (ack_sel) begin
          release_now = 1'b1;
          cnt_d       = '0;
        end else if (cnt_q == TO_TERM) begin
          release_now = 1'b1;
          timed_out   = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
      end
    endcase

    if (release_now) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (SW'(i) == stage_q) begin
          rst_d[i] = 1'b1;
          if (timed_out) begin
            fault_d[i] = 1'b1;
          end
        end
      end
      stage_d = stage_q + SW'(1);
      if (stage_q == LAST) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        state_d = RUN;
      end
    end

    if (i_restart) begin
      state_d = HOLD;
      cnt_d   = '0;
      stage_d = '0;
      rst_d   = '0;
      done_d  = 1'b0;
      fault_d = '0;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stage_q <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  assign o_rst_n = rst_q;
  assign o_done  = done_q;
  assign o_stage = stage_q;
  assign o_fault = fault_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: three instances (plain, ack on stage 1,
// zero delays) driven from checkpoint tables plus a few hand-written sequences.
module tb_reset_sequencer;

  localparam int unsigned     NC  = 3;
  localparam int unsigned     CW  = 8;
  localparam logic [NC*CW-1:0] DLY = {8'd2, 8'd8, 8'd4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n   [3];
  logic          restart [3];
  logic [NC-1:0] ack     [3];
  logic [NC-1:0] orst    [3];
  logic          done    [3];
  logic [1:0]    stage   [3];
  logic [NC-1:0] fault   [3];

  reset_sequencer #(
    .N_CH(NC), .CNT_W(CW), .DELAY(DLY), .ACK_MASK(3'b000), .TIMEOUT(32'd16)
  ) dut_plain (
    .i_clk(clk), .i_rst_n(rst_n[0]), .i_restart(restart[0]), .i_ack(ack[0]),
    .o_rst_n(orst[0]), .o_done(done[0]), .o_stage(stage[0]), .o_fault(fault[0])
  );

  reset_sequencer #(
    .N_CH(NC), .CNT_W(CW), .DELAY(DLY), .ACK_MASK(3'b010), .TIMEOUT(32'd16)
  ) dut_ack (
    .i_clk(clk), .i_rst_n(rst_n[1]), .i_restart(restart[1]), .i_ack(ack[1]),
    .o_rst_n(orst[1]), .o_done(done[1]), .o_stage(stage[1]), .o_fault(fault[1])
  );

  reset_sequencer #(
    .N_CH(NC), .CNT_W(CW), .DELAY('0), .ACK_MASK(3'b000), .TIMEOUT(32'd16)
  ) dut_zero (
    .i_clk(clk), .i_rst_n(rst_n[2]), .i_restart(restart[2]), .i_ack(ack[2]),
    .o_rst_n(orst[2]), .o_done(done[2]), .o_stage(stage[2]), .o_fault(fault[2])
  );

  typedef struct {
    int unsigned e;
    logic [2:0]  rst;
    logic        dn;
    logic [1:0]  stg;
    logic [2:0]  flt;
    logic        rs;
    logic [2:0]  ak;
  } vec_t;

  vec_t        tv[$];
  int unsigned ecnt;
  int unsigned n_checks;
  int unsigned n_fail;

  function automatic void add(input int unsigned e, input logic [2:0] rst,
                              input logic dn, input logic [1:0] stg,
                              input logic [2:0] flt, input logic rs,
                              input logic [2:0] ak);
    tv.push_back('{e, rst, dn, stg, flt, rs, ak});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, ecnt, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input int unsigned sel, input logic [2:0] rst,
                            input logic dn, input logic [1:0] stg, input logic [2:0] flt);
    check({name, ".rst_n"}, 32'(orst[sel]), 32'(rst));
    check({name, ".done"}, 32'(done[sel]), 32'(dn));
    check({name, ".stage"}, 32'(stage[sel]), 32'(stg));
    check({name, ".fault"}, 32'(fault[sel]), 32'(flt));
  endtask

  task automatic step();
    @(posedge clk);
    ecnt++;
    #1;
  endtask

  task automatic release_reset(input int unsigned sel);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n[sel] = 1'b1;
    ecnt = 0;
  endtask

  task automatic do_reset(input string name, input int unsigned sel);
    @(negedge clk);
    restart[sel] = 1'b0;
    ack[sel]     = '0;
    rst_n[sel]   = 1'b0;
    #1;
    check_outs({name, ".reset"}, sel, 3'b000, 1'b0, 2'd0, 3'b000);
    release_reset(sel);
  endtask

  task automatic run_vectors(input string name, input int unsigned sel);
    foreach (tv[i]) begin
      while (ecnt < tv[i].e) step();
      check_outs(name, sel, tv[i].rst, tv[i].dn, tv[i].stg, tv[i].flt);
      restart[sel] = tv[i].rs;
      ack[sel]     = tv[i].ak;
    end
    tv.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ecnt     = 0;
    for (int i = 0; i < 3; i++) begin
      rst_n[i]   = 1'b0;
      restart[i] = 1'b0;
      ack[i]     = '0;
    end

    // Plain sequence: releases at edges 4, 12, 14.
    do_reset("plain", 0);
    add(3,  3'b000, 0, 0, 3'b000, 0, 3'b000);
    add(4,  3'b001, 0, 1, 3'b000, 0, 3'b000);
    add(11, 3'b001, 0, 1, 3'b000, 0, 3'b000);
    add(12, 3'b011, 0, 2, 3'b000, 0, 3'b000);
    add(13, 3'b011, 0, 2, 3'b000, 0, 3'b000);
    add(14, 3'b111, 1, 3, 3'b000, 0, 3'b000);
    add(20, 3'b111, 1, 3, 3'b000, 0, 3'b000);
    run_vectors("plain", 0);

    // Restart high sampled at 10, low sampled at 15.
    do_reset("restart", 0);
    add(4,  3'b001, 0, 1, 3'b000, 0, 3'b000);
    add(9,  3'b001, 0, 1, 3'b000, 1, 3'b000);
    add(10, 3'b000, 0, 0, 3'b000, 1, 3'b000);
    add(14, 3'b000, 0, 0, 3'b000, 0, 3'b000);
    add(15, 3'b000, 0, 0, 3'b000, 0, 3'b000);
    add(17, 3'b000, 0, 0, 3'b000, 0, 3'b000);
    add(18, 3'b001, 0, 1, 3'b000, 0, 3'b000);
    add(25, 3'b001, 0, 1, 3'b000, 0, 3'b000);
    add(26, 3'b011, 0, 2, 3'b000, 0, 3'b000);
    add(27, 3'b011, 0, 2, 3'b000, 0, 3'b000);
    add(28, 3'b111, 1, 3, 3'b000, 0, 3'b000);
    run_vectors("restart", 0);

    // Ack high from the start costs no extra cycles.
    do_reset("early_ack", 1);
    ack[1] = 3'b010;
    add(11, 3'b001, 0, 1, 3'b000, 0, 3'b010);
    add(12, 3'b011, 0, 2, 3'b000, 0, 3'b010);
    add(14, 3'b111, 1, 3, 3'b000, 0, 3'b000);
    run_vectors("early_ack", 1);

    // Late ack sampled at 20 releases stage 1 at 22; ack drop afterwards is ignored.
    do_reset("late_ack", 1);
    add(11, 3'b001, 0, 1, 3'b000, 0, 3'b000);
    add(12, 3'b001, 0, 1, 3'b000, 0, 3'b000);
    add(19, 3'b001, 0, 1, 3'b000, 0, 3'b010);
    add(21, 3'b001, 0, 1, 3'b000, 0, 3'b010);
    add(22, 3'b011, 0, 2, 3'b000, 0, 3'b000);
    add(23, 3'b011, 0, 2, 3'b000, 0, 3'b000);
    add(24, 3'b111, 1, 3, 3'b000, 0, 3'b000);
    add(30, 3'b111, 1, 3, 3'b000, 0, 3'b000);
    run_vectors("late_ack", 1);

    // Timeout at 28 sets fault; restart at 41 clears it, stage 0 again at 45.
    do_reset("timeout", 1);
    add(12, 3'b001, 0, 1, 3'b000, 0, 3'b000);
    add(27, 3'b001, 0, 1, 3'b000, 0, 3'b000);
    add(28, 3'b011, 0, 2, 3'b010, 0, 3'b000);
    add(29, 3'b011, 0, 2, 3'b010, 0, 3'b000);
    add(30, 3'b111, 1, 3, 3'b010, 0, 3'b000);
    add(40, 3'b111, 1, 3, 3'b010, 1, 3'b000);
    add(41, 3'b000, 0, 0, 3'b000, 0, 3'b000);
    add(42, 3'b000, 0, 0, 3'b000, 0, 3'b000);
    add(44, 3'b000, 0, 0, 3'b000, 0, 3'b000);
    add(45, 3'b001, 0, 1, 3'b000, 0, 3'b000);
    run_vectors("timeout", 1);

    // Async reset while waiting for ack, then the timeout timing repeats.
    do_reset("async_rst", 1);
    add(20, 3'b001, 0, 1, 3'b000, 0, 3'b000);
    run_vectors("async_rst.pre", 1);
    #3;
    rst_n[1] = 1'b0;
    #1;
    check_outs("async_rst.mid", 1, 3'b000, 1'b0, 2'd0, 3'b000);
    release_reset(1);
    add(4,  3'b001, 0, 1, 3'b000, 0, 3'b000);
    add(27, 3'b001, 0, 1, 3'b000, 0, 3'b000);
    add(28, 3'b011, 0, 2, 3'b010, 0, 3'b000);
    add(30, 3'b111, 1, 3, 3'b010, 0, 3'b000);
    run_vectors("async_rst.post", 1);

    // Zero delays: one stage per edge; restart low edge releases stage 0 at once.
    do_reset("zero", 2);
    add(1, 3'b001, 0, 1, 3'b000, 0, 3'b000);
    add(2, 3'b011, 0, 2, 3'b000, 0, 3'b000);
    add(3, 3'b111, 1, 3, 3'b000, 0, 3'b000);
    add(5, 3'b111, 1, 3, 3'b000, 1, 3'b000);
    add(6, 3'b000, 0, 0, 3'b000, 0, 3'b000);
    add(7, 3'b001, 0, 1, 3'b000, 0, 3'b000);
    add(8, 3'b011, 0, 2, 3'b000, 0, 3'b000);
    add(9, 3'b111, 1, 3, 3'b000, 0, 3'b000);
    run_vectors("zero", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

- Parametrised power-on reset sequencer: drives `N_CH` active-low reset outputs and releases them one at a time, in index order.
- Each stage has its own delay, measured relative to the release of the previous stage.
- Each stage can optionally wait for a ready/lock acknowledge (PLL lock, SDRAM init done), guarded by a timeout.
- Sits at the top level between the board reset button and all downstream clients; supports a synchronous software-requested restart.

## Interface

Parameters:
- `N_CH`, default 5: number of sequenced reset outputs (1..16).
- `CNT_W`, default 26: width of the shared delay/timeout counter.
- `DELAY`, default 5×`CNT_W`'h1FFFFF: packed delays; stage k uses `DELAY[k*CNT_W +: CNT_W]`, in cycles.
- `ACK_MASK`, default 0: bit k=1 means stage k also requires `i_ack[k]` before release.
- `TIMEOUT`, default 2**`CNT_W`-1: maximum cycles spent waiting for an acknowledge.

Ports (one clock; reset is asynchronous and active-low):
- `i_clk` — in, 1 — system clock.
- `i_rst_n` — in, 1 — asynchronous active-low reset.
- `i_restart` — in, 1 — synchronous level; restarts the sequence.
- `i_ack` — in, `N_CH` — asynchronous acknowledges; synchronised internally.
- `o_rst_n` — out, `N_CH` — sequenced active-low resets.
- `o_done` — out, 1 — all stages released.
- `o_stage` — out, `$clog2(N_CH+1)` — index of the current stage; equals `N_CH` once done.
- `o_fault` — out, `N_CH` — sticky flag per stage: released by timeout, not by acknowledge.

## Operation

- Reset (`i_rst_n`=0) forces, asynchronously:
  - `o_rst_n`=0, `o_done`=0, `o_stage`=0, `o_fault`=0;
  - state RUN, counter 0, synchroniser flops 0.
- States:
  - **HOLD**: `i_restart` high.
  - **RUN**: counting the stage delay.
  - **WAIT_ACK**: waiting for the stage acknowledge.
  - **DONE**: all stages released.
- **RUN, stage k**: counter increments every edge. Let D = max(`DELAY`[k], 1); a delay of 0 is treated as 1. On the edge where counter == D-1:
  - if `ACK_MASK[k]`=0, or synchronised ack[k]=1: set `o_rst_n[k]`=1, clear the counter, advance k.
  - otherwise: clear the counter and enter WAIT_ACK.
- **WAIT_ACK, stage k**:
  - First edge with synchronised ack[k]=1: release stage k and return to RUN for k+1.
  - Otherwise the counter increments. On the edge where counter == `TIMEOUT`-1, release stage k anyway and set `o_fault[k]`=1.
- After the last stage is released: enter DONE, set `o_done`=1, `o_stage`=`N_CH`, freeze the counter (no wrap).
- **`i_restart`** sampled high in any state:
  - next state HOLD; `o_rst_n`=0, `o_done`=0, `o_stage`=0, counter 0;
  - `o_fault` is cleared on entering HOLD.
  - The edge sampling `i_restart` low leaves HOLD and counts as RUN cycle 1 of stage 0.
- A deasserting `i_ack` after its stage is released has no effect; a released stage is never re-asserted except by reset or restart.
- `o_rst_n` bits are monotonic: bit k rises no earlier than bit k-1.

## Timing

- Edge numbering: edge 1 is the first rising edge with `i_rst_n` high (or with `i_restart` sampled low).
- With no acknowledges required, `o_rst_n[k]` rises at edge Σ_{j≤k} max(`DELAY`[j],1); `o_done` rises on the same edge as the last bit.
- Acknowledge path:
  - 2-flop synchroniser, so 2 cycles from `i_ack` to the FSM.
  - An ack already high at the delay's terminal edge costs 0 extra cycles.
  - An ack that rises in WAIT_ACK and is sampled at edge t releases the stage at edge t+2.
- Assertion of `i_rst_n` is asynchronous. All deassertions are synchronous to `i_clk`, and all outputs are registered.
- Widths: each `DELAY` entry and `TIMEOUT` must be < 2**`CNT_W`; elaboration error otherwise. Require `TIMEOUT`≥1.

## Structure

- Package `reset_seq_pkg`:
  - state enum `rs_state_e` {HOLD, RUN, WAIT_ACK, DONE};
  - function `f_delay(k)` extracting the clamped delay for stage k;
  - default `CNT_W` constant.
- Sub-module `sync_2ff` (parameter `W`, async active-low reset to 0) synchronises `i_ack`.
- One FSM with a single shared counter used for both delays and timeouts.

## Test plan

All scenarios use `N_CH`=3, `CNT_W`=8, `DELAY`={2,8,4} (stages 2,1,0), `TIMEOUT`=16.

1. **Plain sequence**, `ACK_MASK`=0 → `o_rst_n` = 001 @edge4, 011 @12, 111 @14; `o_done`=1 @14; `o_stage` = 0→1→2→3; `o_fault`=0.
2. **Late acknowledge**, `ACK_MASK`=010, `i_ack[1]` raised before edge 20 → WAIT_ACK from edge 12; `o_rst_n[1]` rises @22, `o_rst_n[2]` @24; `o_fault`=000.
3. **Timeout**, `ACK_MASK`=010, `i_ack` held 0 → `o_rst_n[1]` @28 with `o_fault`=010; `o_rst_n[2]` @30; `o_done` @30; fault persists in DONE.
4. **Restart mid-sequence**: `i_restart` high sampled @10, low sampled @15 → `o_rst_n`=000 after edge 10; restart clears the fault; `o_rst_n[0]` rises @18, `o_done` @28.
5. **Async reset mid-wait**: in scenario 3, drop `i_rst_n` between edges 20 and 21 → `o_rst_n`=000 and `o_stage`=0 before the next clock edge. After release, the sequence repeats scenario 3 timing.
6. **Zero delay**: `DELAY`={0,0,0}, `ACK_MASK`=0 → `o_rst_n` = 001 @1, 011 @2, 111 @3; `o_done` @3.
